// File: rtl/door_lock_pkg.sv
// ----------------------------------------------------------------------------
// door_lock_pkg
// Shared definitions for the motorised door-lock controller.
//   - S_* : state encoding constants used by the controller FSM register
//   - state_e : enum view of the same encoding (handy in waveforms/debug)
//   - is_moving() : true for the two motor-driving states
// ----------------------------------------------------------------------------
package door_lock_pkg;

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_LOCKED    = 3'd1;
    localparam logic [2:0] S_UNLOCKING = 3'd2;
    localparam logic [2:0] S_UNLOCKED  = 3'd3;
    localparam logic [2:0] S_LOCKING   = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    typedef enum logic [2:0] {
        STATE_INIT      = S_INIT,
        STATE_LOCKED    = S_LOCKED,
        STATE_UNLOCKING = S_UNLOCKING,
        STATE_UNLOCKED  = S_UNLOCKED,
        STATE_LOCKING   = S_LOCKING,
        STATE_FAULT     = S_FAULT
    } state_e;

    function automatic logic is_moving(input logic [2:0] st);
        return (st == S_LOCKING) || (st == S_UNLOCKING);
    endfunction

endpackage

// File: rtl/door_lock_ctrl_if.sv
// ----------------------------------------------------------------------------
// door_lock_ctrl_if
// Groups the front-panel / end-stop inputs and motor / status outputs of the
// door-lock controller.
//   master : the surrounding board (drives PRESS and end-stops, observes outputs)
//   slave  : the controller itself
// Signals:
//   PRESS        user button, synchronised level
//   LIM_LOCKED   end-stop, bolt fully locked
//   LIM_UNLOCKED end-stop, bolt fully retracted
//   M_CW / M_ACW motor drive towards locked / unlocked
//   LOCKED, BUSY, FAULT status
// ----------------------------------------------------------------------------
interface door_lock_ctrl_if;
    logic PRESS;
    logic LIM_LOCKED;
    logic LIM_UNLOCKED;
    logic M_CW;
    logic M_ACW;
    logic LOCKED;
    logic BUSY;
    logic FAULT;

    modport master (
        output PRESS, LIM_LOCKED, LIM_UNLOCKED,
        input  M_CW, M_ACW, LOCKED, BUSY, FAULT
    );

    modport slave (
        input  PRESS, LIM_LOCKED, LIM_UNLOCKED,
        output M_CW, M_ACW, LOCKED, BUSY, FAULT
    );
endinterface

// File: rtl/door_lock_debounce.sv
// ----------------------------------------------------------------------------
// door_lock_debounce
// Turns a level button input into a single-cycle registered press event once
// DEBOUNCE_CYCLES consecutive high samples have been seen. A low sample
// restarts the run; holding the button produces exactly one event.
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset (clears the run count)
//   PRESS      synchronised button level
//   press_evt  one-cycle pulse, registered
// ----------------------------------------------------------------------------
module door_lock_debounce #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic PRESS,
    output logic press_evt
);
    import door_lock_pkg::*;

    localparam logic [CNT_W-1:0] RUN_FULL = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] run_q, run_d;
    logic             evt_q, evt_d;

    // The run counter saturates at DEBOUNCE_CYCLES so a held button cannot
    // re-trigger; the event fires on the sample that completes the run.
    always_comb begin
        run_d = run_q;
        evt_d = 1'b0;
        if (!PRESS) begin
            run_d = '0;
        end else if (run_q != RUN_FULL) begin
            run_d = run_q + CNT_W'(1);
            evt_d = (run_q == RUN_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            run_q <= '0;
            evt_q <= 1'b0;
        end else begin
            run_q <= run_d;
            evt_q <= evt_d;
        end
    end

    assign press_evt = evt_q;

endmodule

// File: rtl/door_lock_ctrl.sv
// ----------------------------------------------------------------------------
// door_lock_ctrl
// Motorised door-lock controller: debounced button, limit-switch terminated
// motor moves with a timeout, fault state and fail-secure start-up (an
// unknown bolt position at start-up is driven towards locked).
// Optional feature macro: DOOR_LOCK_AUTO_RELOCK_EN -- when defined, the door
// relocks by itself after RELOCK_CYCLES cycles in UNLOCKED.
// Ports:
//   CLK  clock
//   RST  synchronous active-high reset
//   bus  door_lock_ctrl_if.slave: PRESS, LIM_LOCKED, LIM_UNLOCKED in;
//        M_CW, M_ACW, LOCKED, BUSY, FAULT out (Moore, from state only)
// ----------------------------------------------------------------------------
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int MOTOR_TIMEOUT   = 1000,
    parameter int RELOCK_CYCLES   = 10000,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RST,
    door_lock_ctrl_if.slave  bus
);

    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= CNT_LIMIT) begin : g_bad_debounce
        $error("door_lock_ctrl: DEBOUNCE_CYCLES out of range");
    end
    if (MOTOR_TIMEOUT < 2 || longint'(MOTOR_TIMEOUT) >= CNT_LIMIT) begin : g_bad_timeout
        $error("door_lock_ctrl: MOTOR_TIMEOUT out of range");
    end
    if (RELOCK_CYCLES < 1 || longint'(RELOCK_CYCLES) >= CNT_LIMIT) begin : g_bad_relock
        $error("door_lock_ctrl: RELOCK_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MOTOR_TIMEOUT - 1);

    logic             press_evt;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             lim_both;

    door_lock_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .CLK       (CLK),
        .RST       (RST),
        .PRESS     (bus.PRESS),
        .press_evt (press_evt)
    );

    assign lim_both = bus.LIM_LOCKED && bus.LIM_UNLOCKED;

`ifdef DOOR_LOCK_AUTO_RELOCK_EN
    localparam logic [CNT_W-1:0] RELOCK_LAST = CNT_W'(RELOCK_CYCLES - 1);
    logic [CNT_W-1:0] relock_q, relock_d;
    logic             relock_due;
    assign relock_due = (relock_q == RELOCK_LAST);
`else
    logic relock_due;
    assign relock_due = 1'b0;
`endif

    // Next-state logic. press_evt is only looked at in the resting states, so
    // a press coinciding with a limit/timeout in a moving state is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      state_d = bus.LIM_LOCKED ? S_LOCKED : S_LOCKING;
            S_LOCKED:    if (press_evt) state_d = S_UNLOCKING;
            S_UNLOCKED:  if (press_evt || relock_due) state_d = S_LOCKING;
            S_UNLOCKING: begin
                if (bus.LIM_UNLOCKED)        state_d = S_UNLOCKED;
                else if (timer_q == TMO_LAST) state_d = S_FAULT;
            end
            S_LOCKING: begin
                if (bus.LIM_LOCKED)          state_d = S_LOCKED;
                else if (timer_q == TMO_LAST) state_d = S_FAULT;
            end
            S_FAULT:     if (press_evt) state_d = S_LOCKING;
            default:     state_d = S_INIT;
        endcase
        // Contradictory end-stops override everything outside INIT/FAULT.
        if (lim_both && state_q != S_INIT && state_q != S_FAULT) begin
            state_d = S_FAULT;
        end
    end

    // Motor timer: zero on the first cycle of a move, counts while staying.
    always_comb begin
        timer_d = '0;
        if (is_moving(state_q) && state_d == state_q) begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

`ifdef DOOR_LOCK_AUTO_RELOCK_EN
    always_comb begin
        relock_d = '0;
        if (state_q == S_UNLOCKED && state_d == S_UNLOCKED) begin
            relock_d = relock_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) relock_q <= '0;
        else     relock_q <= relock_d;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_INIT;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign bus.M_CW   = (state_q == S_LOCKING);
    assign bus.M_ACW  = (state_q == S_UNLOCKING);
    assign bus.BUSY   = is_moving(state_q);
    assign bus.LOCKED = (state_q == S_LOCKED);
    assign bus.FAULT  = (state_q == S_FAULT);

endmodule

// File: tb/tb_door_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_door_lock_ctrl
// Directed scenarios plus a randomized run checked against a dwell-time based
// behavioural model of the lock. Inputs change on the falling edge, outputs
// are observed on the falling edge.
// ----------------------------------------------------------------------------
module tb_door_lock_ctrl;

    localparam int D = 3;
    localparam int T = 8;
    localparam int R = 20;

    // Observed output vector: {LOCKED, BUSY, FAULT, M_CW, M_ACW}
    localparam logic [4:0] O_IDLE   = 5'b00000;
    localparam logic [4:0] O_LOCKED = 5'b10000;
    localparam logic [4:0] O_CW     = 5'b01010;
    localparam logic [4:0] O_ACW    = 5'b01001;
    localparam logic [4:0] O_FAULT  = 5'b00100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    door_lock_ctrl_if bus();

    door_lock_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .MOTOR_TIMEOUT   (T),
        .RELOCK_CYCLES   (R),
        .CNT_W           (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [4:0] outs();
        return {bus.LOCKED, bus.BUSY, bus.FAULT, bus.M_CW, bus.M_ACW};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, then release into LOCKED (LIM_LOCKED=1, no press).
    task automatic go_locked();
        rst = 1'b1; bus.PRESS = 1'b0; bus.LIM_LOCKED = 1'b1; bus.LIM_UNLOCKED = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_INIT = 0, M_LOCKED = 1, M_UNLOCKING = 2,
                   M_UNLOCKED = 3, M_LOCKING = 4, M_FAULT = 5;
    int m_st, m_run, m_age;
    bit m_evt;

    // Advance the model by one clock edge using the inputs sampled there.
    // m_age = number of cycles already spent in the current state.
    task automatic model_step();
        int nst;
        bit ll, lu;
        ll = bus.LIM_LOCKED;
        lu = bus.LIM_UNLOCKED;
        if (rst) begin
            m_st = M_INIT; m_run = 0; m_evt = 0; m_age = 1;
            return;
        end
        nst = m_st;
        case (m_st)
            M_INIT:      nst = ll ? M_LOCKED : M_LOCKING;
            M_LOCKED:    if (m_evt) nst = M_UNLOCKING;
            M_UNLOCKED: begin
                if (m_evt) nst = M_LOCKING;
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
                if (m_age == R) nst = M_LOCKING;
`endif
            end
            M_UNLOCKING: if (lu) nst = M_UNLOCKED; else if (m_age == T) nst = M_FAULT;
            M_LOCKING:   if (ll) nst = M_LOCKED;   else if (m_age == T) nst = M_FAULT;
            M_FAULT:     if (m_evt) nst = M_LOCKING;
            default:     nst = M_INIT;
        endcase
        if (ll && lu && m_st != M_INIT && m_st != M_FAULT) nst = M_FAULT;
        m_age = (nst == m_st) ? m_age + 1 : 1;
        m_st  = nst;
        m_run = bus.PRESS ? m_run + 1 : 0;
        m_evt = (m_run == D);
    endtask

    function automatic logic [4:0] model_outs(input int st);
        case (st)
            M_LOCKED:    return O_LOCKED;
            M_UNLOCKING: return O_ACW;
            M_LOCKING:   return O_CW;
            M_FAULT:     return O_FAULT;
            default:     return O_IDLE;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; bus.PRESS = 1'b0; bus.LIM_LOCKED = 1'b1; bus.LIM_UNLOCKED = 1'b0;
        tick(); tick();
        n_checks++;
        if (outs() !== O_IDLE) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", outs(), O_IDLE); end
        rst = 1'b0;
        n_checks++;
        if (outs() !== O_IDLE) begin n_fail++; $display("FAIL init_cycle: got %b want %b", outs(), O_IDLE); end
        tick();
        n_checks++;
        if (outs() !== O_LOCKED) begin n_fail++; $display("FAIL init_to_locked: got %b want %b", outs(), O_LOCKED); end
        rst = 1'b1; bus.LIM_LOCKED = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_IDLE) begin n_fail++; $display("FAIL reset_from_locked: got %b want %b", outs(), O_IDLE); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_CW) begin n_fail++; $display("FAIL init_fail_secure: got %b want %b", outs(), O_CW); end
        go_locked();
    endtask

    task automatic test_unlock();
        bus.PRESS = 1'b1;
        tick(); tick();
        n_checks++;
        if (outs() !== O_LOCKED) begin n_fail++; $display("FAIL no_early_unlock: got %b want %b", outs(), O_LOCKED); end
        tick();
        n_checks++;
        if (outs() !== O_LOCKED) begin n_fail++; $display("FAIL evt_cycle_locked: got %b want %b", outs(), O_LOCKED); end
        bus.PRESS = 1'b0; bus.LIM_LOCKED = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_ACW) begin n_fail++; $display("FAIL unlocking_entered: got %b want %b", outs(), O_ACW); end
        tick();
        n_checks++;
        if (outs() !== O_ACW) begin n_fail++; $display("FAIL unlocking_held: got %b want %b", outs(), O_ACW); end
        bus.LIM_UNLOCKED = 1'b1;
        tick();
        n_checks++;
        if (outs() !== O_IDLE) begin n_fail++; $display("FAIL unlocked_on_limit: got %b want %b", outs(), O_IDLE); end
        bus.PRESS = 1'b1;
        tick(); tick();
        bus.PRESS = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (outs() !== O_IDLE) begin n_fail++; $display("FAIL glitch_ignored: got %b want %b", outs(), O_IDLE); end
    endtask

    // Starts in UNLOCKED (left there by test_unlock).
    task automatic test_timeout();
        int cnt;
        bus.PRESS = 1'b1;
        repeat (D) tick();
        bus.PRESS = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_CW) begin n_fail++; $display("FAIL locking_entered: got %b want %b", outs(), O_CW); end
        bus.LIM_UNLOCKED = 1'b0;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (outs() == O_CW) cnt++;
            else break;
        end
        n_checks++;
        if (cnt !== T) begin n_fail++; $display("FAIL mcw_duration: got %0d cycles want %0d", cnt, T); end
        n_checks++;
        if (outs() !== O_FAULT) begin n_fail++; $display("FAIL timeout_fault: got %b want %b", outs(), O_FAULT); end
        bus.PRESS = 1'b1;
        repeat (D) tick();
        bus.PRESS = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_CW) begin n_fail++; $display("FAIL fault_retry: got %b want %b", outs(), O_CW); end
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (outs() !== O_IDLE) begin n_fail++; $display("FAIL rst_mid_move: got %b want %b", outs(), O_IDLE); end
        bus.LIM_LOCKED = 1'b1;
        rst = 1'b0;
        tick();
        n_checks++;
        if (outs() !== O_LOCKED) begin n_fail++; $display("FAIL rst_reinit_locked: got %b want %b", outs(), O_LOCKED); end
    endtask

    task automatic test_both_limits();
        bus.PRESS = 1'b1;
        repeat (D) tick();
        bus.PRESS = 1'b0; bus.LIM_LOCKED = 1'b0;
        tick();
        bus.LIM_UNLOCKED = 1'b1;
        tick();
        n_checks++;
        if (outs() !== O_IDLE) begin n_fail++; $display("FAIL reach_unlocked: got %b want %b", outs(), O_IDLE); end
        bus.LIM_LOCKED = 1'b1;
        tick();
        n_checks++;
        if (outs() !== O_FAULT) begin n_fail++; $display("FAIL both_limits_fault: got %b want %b", outs(), O_FAULT); end
        go_locked();
    endtask

    task automatic test_hold_press();
        int entries;
        logic [4:0] prev, cur;
        entries = 0;
        prev = outs();
        bus.PRESS = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cur = outs();
            if (cur == O_ACW && prev != O_ACW) entries++;
            prev = cur;
        end
        bus.PRESS = 1'b0;
        n_checks++;
        if (entries !== 1) begin n_fail++; $display("FAIL hold_single_entry: got %0d entries want 1", entries); end
        n_checks++;
        if (outs() !== O_FAULT) begin n_fail++; $display("FAIL hold_then_timeout: got %b want %b", outs(), O_FAULT); end
        go_locked();
    endtask

    task automatic test_relock();
        int cnt;
        bus.PRESS = 1'b1;
        repeat (D) tick();
        bus.PRESS = 1'b0; bus.LIM_LOCKED = 1'b0;
        tick();
        bus.LIM_UNLOCKED = 1'b1;
        tick();
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (outs() == O_IDLE) cnt++;
            else break;
        end
        n_checks++;
        if (cnt !== R) begin n_fail++; $display("FAIL relock_delay: got %0d cycles want %0d", cnt, R); end
        n_checks++;
        if (outs() !== O_CW) begin n_fail++; $display("FAIL relock_locking: got %b want %b", outs(), O_CW); end
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (outs() == O_IDLE) cnt++;
        end
        n_checks++;
        if (cnt !== 100) begin n_fail++; $display("FAIL no_relock: unlocked %0d of 100 cycles", cnt); end
`endif
        go_locked();
    endtask

    task automatic test_random();
        logic [4:0] exp;
        rst = 1'b1; bus.PRESS = 1'b0; bus.LIM_LOCKED = 1'b0; bus.LIM_UNLOCKED = 1'b0;
        @(posedge clk); #1; model_step();
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            exp = model_outs(m_st);
            n_checks++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %b want %b (model state %0d)", c, outs(), exp, m_st);
            end
            if ($urandom_range(0, 3) == 0) bus.PRESS = ~bus.PRESS;
            bus.LIM_LOCKED   = ($urandom_range(0, 9) < 2);
            bus.LIM_UNLOCKED = ($urandom_range(0, 9) < 2);
            rst              = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1; model_step();
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.PRESS = 1'b0;
        bus.LIM_LOCKED = 1'b0;
        bus.LIM_UNLOCKED = 1'b0;
        @(negedge clk);
        test_reset();
        test_unlock();
        test_timeout();
        test_both_limits();
        test_hold_press();
        test_relock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
